regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32 x 16-bit register file and shares it between NREQ writeback requesters, such as the ALU and the load unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write so the register file sees clean RegWrite/Rd/Write_data one cycle after acceptance.
- Optionally runs a post-reset zeroing sweep of all 32 registers before accepting traffic.

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the 32 x 16-bit register file and shares it
//   between NREQ writeback requesters using round-robin arbitration with a
//   valid/ready handshake per requester. The winning write is registered so
//   the register file sees clean RegWrite/Rd/Write_data one cycle after
//   acceptance. Writes to x0 are accepted but never reach the register file.
//
//   Optional feature (compile-time macro REGWB_INIT_SWEEP_EN):
//     defined   - after reset, sweep Rd=0..31 writing zero before arbitration
//                 starts; init_done rises 33 cycles after reset release.
//     undefined - no sweep logic; arbitration is enabled from the first clock
//                 edge after reset release.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   req_valid    [NREQ]     per-requester write request
//   req_rd       [NREQ*AW]  destination index, requester i at [i*AW +: AW]
//   req_data     [NREQ*DW]  write data, requester i at [i*DW +: DW]
//   req_ready    [NREQ]     combinational accept, one-hot or zero
//   RegWrite                registered register-file write enable
//   Rd           [AW]       registered register-file write index
//   Write_data   [DW]       registered register-file write data
//   grant_id     [2]        requester that produced the current RegWrite
//   init_done               high once arbitration is enabled
//   conflict_cnt [16]       saturating count of multi-request cycles in ARB
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 16,
  parameter int AW   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               RegWrite,
  output logic [AW-1:0]      Rd,
  output logic [DW-1:0]      Write_data,
  output logic [1:0]         grant_id,
  output logic               init_done,
  output logic [15:0]        conflict_cnt
);

  localparam int GW = 2;

`ifdef REGWB_INIT_SWEEP_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_ARB  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] sweep_cnt;
`endif

  logic [GW-1:0]   last_grant;
  logic [NREQ-1:0] sel_onehot;
  logic [GW-1:0]   sel_id;
  logic            sel_any;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            multi_req;
  logic            xfer;
  int              idx;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel_onehot = '0;
    sel_id     = '0;
    sel_any    = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!sel_any && req_valid[idx]) begin
        sel_any         = 1'b1;
        sel_id          = GW'(idx);
        sel_onehot[idx] = 1'b1;
      end
    end
  end

  assign sel_rd    = req_rd[int'(sel_id)*AW +: AW];
  assign sel_data  = req_data[int'(sel_id)*DW +: DW];
  assign multi_req = ($countones(req_valid) >= 2);

  // init_done is the single arbitration enable: it is low in reset, during
  // the sweep and for the one cycle after the sweep's last write.
  assign req_ready = init_done ? sel_onehot : '0;
  assign xfer      = init_done & sel_any;

  // Stage boundary: accepted request -> registered register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite     <= 1'b0;
      Rd           <= '0;
      Write_data   <= '0;
      grant_id     <= '0;
      init_done    <= 1'b0;
      conflict_cnt <= '0;
      last_grant   <= GW'(NREQ-1);
`ifdef REGWB_INIT_SWEEP_EN
      state        <= ST_INIT;
      sweep_cnt    <= '0;
`endif
    end else begin
      RegWrite <= 1'b0;
`ifdef REGWB_INIT_SWEEP_EN
      init_done <= (state == ST_ARB);
      if (state == ST_INIT) begin
        RegWrite   <= 1'b1;
        Rd         <= sweep_cnt;
        Write_data <= '0;
        sweep_cnt  <= sweep_cnt + 1'b1;
        if (sweep_cnt == '1) begin
          state <= ST_ARB;
        end
      end
`else
      init_done <= 1'b1;
`endif
      if (xfer) begin
        // x0 is hard-wired zero: accept the write but never enable it.
        RegWrite   <= (sel_rd != '0);
        Rd         <= sel_rd;
        Write_data <= sel_data;
        grant_id   <= sel_id;
        last_grant <= sel_id;
      end
      if (init_done && multi_req && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               RegWrite;
  logic [AW-1:0]      Rd;
  logic [DW-1:0]      Write_data;
  logic [1:0]         grant_id;
  logic               init_done;
  logic [15:0]        conflict_cnt;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .RegWrite     (RegWrite),
    .Rd           (Rd),
    .Write_data   (Write_data),
    .grant_id     (grant_id),
    .init_done    (init_done),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side stimulus state
  logic [AW-1:0] rd_q   [NREQ];
  logic [DW-1:0] dat_q  [NREQ];
  bit            oneshot[NREQ];
  bit            rand_mode;

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*AW +: AW]   = rd_q[i];
      req_data[i*DW +: DW] = dat_q[i];
    end
  end

  // Reference model: expected registered outputs and arbitration pointer
  bit            m_init;
  int            m_sweep;
  int            m_last;
  bit            m_rw;
  int            m_rd;
  int            m_data;
  int            m_gid;
  int            m_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sweep_start();
`ifdef REGWB_INIT_SWEEP_EN
    return 0;
`else
    return 32;
`endif
  endfunction

  task automatic model_reset();
    m_init  = 1'b0;
    m_sweep = sweep_start();
    m_last  = NREQ - 1;
    m_rw    = 1'b0;
    m_rd    = 0;
    m_data  = 0;
    m_gid   = 0;
    m_cnt   = 0;
  endtask

  // Winner under round-robin rules, or -1 when nothing is granted.
  function automatic int pick();
    int i;
    if (!m_init) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      i = (m_last + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    if (m_init && ($countones(req_valid) >= 2) && m_cnt < 65535) m_cnt++;
    if (m_init) begin
      if (w >= 0) begin
        m_rw   = (rd_q[w] != 0);
        m_rd   = int'(rd_q[w]);
        m_data = int'(dat_q[w]);
        m_gid  = w;
        m_last = w;
      end else begin
        m_rw = 1'b0;
      end
    end else if (m_sweep < 32) begin
      m_rw   = 1'b1;
      m_rd   = m_sweep;
      m_data = 0;
      m_sweep++;
    end else begin
      m_rw   = 1'b0;
      m_init = 1'b1;
    end
  endtask

  // One clock: check ready mid-cycle, advance model, check registered outputs
  task automatic cycle();
    int w;
    logic [NREQ-1:0] er;
    @(negedge clk);
    w  = pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    model_edge(w);
    #1;
    chk("RegWrite", 32'(RegWrite), 32'(m_rw));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("init_done", 32'(init_done), 32'(m_init));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    if (m_rw) begin
      chk("Rd", 32'(Rd), 32'(m_rd));
      chk("Write_data", 32'(Write_data), 32'(m_data));
    end
    if (w >= 0 && oneshot[w]) req_valid[w] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          rd_q[i]      = AW'($urandom);
          dat_q[i]     = DW'($urandom);
        end
      end
    end
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_Rd", 32'(Rd), 32'd0);
    chk("rst_Write_data", 32'(Write_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int n;
  int cnt_before;

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rd_q[i]    = '0;
      dat_q[i]   = '0;
      oneshot[i] = 1'b1;
    end
    model_reset();

    req_valid = 2'b11;
    rd_q[0]   = 5'd7;  dat_q[0] = 16'h00AA;
    rd_q[1]   = 5'd9;  dat_q[1] = 16'h5A5A;
    do_reset();

`ifdef REGWB_INIT_SWEEP_EN
    // Reset while the sweep is writing Rd=10, then restart from Rd=0
    for (int c = 0; c < 40 && m_sweep < 11; c++) cycle();
    chk("sweep_at_10", 32'(Rd), 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("midsweep_RegWrite", 32'(RegWrite), 32'd0);
    chk("midsweep_Rd", 32'(Rd), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    chk("sweep_restart_Rd", 32'(Rd), 32'd0);
    chk("sweep_restart_RegWrite", 32'(RegWrite), 32'd1);
    n = 1;
`else
    req_valid[1] = 1'b0;
    n = 0;
`endif

    // First grant after reset release goes to requester 0
    while (req_valid[0] && n < 40) begin
      cycle();
      n++;
    end
`ifdef REGWB_INIT_SWEEP_EN
    chk("first_grant_latency", 32'(n), 32'd34);
`else
    chk("first_grant_latency", 32'(n), 32'd2);
`endif
    chk("first_RegWrite", 32'(RegWrite), 32'd1);
    chk("first_Rd", 32'(Rd), 32'd7);
    chk("first_Write_data", 32'(Write_data), 32'h00AA);
    chk("first_grant_id", 32'(grant_id), 32'd0);
    while (req_valid != '0 && n < 80) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(req_valid), 32'd0);
    cycle();

    // Single request
    rd_q[0] = 5'd5; dat_q[0] = 16'h1234; req_valid[0] = 1'b1;
    cycle();
    chk("single_RegWrite", 32'(RegWrite), 32'd1);
    chk("single_Rd", 32'(Rd), 32'd5);
    chk("single_Write_data", 32'(Write_data), 32'h1234);
    chk("single_grant_id", 32'(grant_id), 32'd0);
    cycle();
    chk("single_after", 32'(RegWrite), 32'd0);

    // x0 write: accepted, never enabled, pointer advances
    rd_q[1] = 5'd0; dat_q[1] = 16'hFFFF; req_valid[1] = 1'b1;
    cycle();
    chk("x0_RegWrite", 32'(RegWrite), 32'd0);
    chk("x0_grant_id", 32'(grant_id), 32'd1);
    chk("x0_dropped_valid", 32'(req_valid), 32'd0);

    // Contention: both held for six cycles, alternating 0,1,0,1,0,1
    cnt_before = m_cnt;
    oneshot[0] = 1'b0; oneshot[1] = 1'b0;
    rd_q[0] = 5'd3; dat_q[0] = 16'hA003;
    rd_q[1] = 5'd4; dat_q[1] = 16'hB004;
    req_valid = 2'b11;
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("cont_grant", 32'(grant_id), 32'(j % 2));
      chk("cont_Rd", 32'(Rd), 32'(3 + (j % 2)));
    end
    req_valid = '0;
    oneshot[0] = 1'b1; oneshot[1] = 1'b1;
    chk("cont_conflicts", 32'(conflict_cnt), 32'(cnt_before + 6));
    cycle();

    // Randomized traffic under the hold-until-ready contract
    rand_mode = 1'b1;
    for (int c = 0; c < 300; c++) cycle();

    // Reset in the middle of traffic, then keep going
    do_reset();
    for (int c = 0; c < 60; c++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
